uart_tx_scheduler: RTL and testbench

- Shares one UART word serializer between NUM_SRC packet buffers in the receive path.
- Grants one pending packet at a time, round-robin.
- Captures the granted packet and pulses that buffer's clear line.
- Emits the packet as 11-bit UART words: one header word carrying the source id, then PACKET_SIZE/8 data words. A valid/ready handshake with the serializer paces each word.

---
 rtl/uart_tx_scheduler.sv | 170 +++++++++++++++++
 tb/tb_uart_tx_scheduler.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_scheduler.sv
// Round-robin scheduler that shares one UART word serializer between
// NUM_SRC packet buffers: grants a pending packet, captures it, clears the
// buffer, then emits a header word followed by the packet bytes MSB-first.
module uart_tx_scheduler #(
  parameter int unsigned NUM_SRC     = 2,
  parameter int unsigned PACKET_SIZE = 32,
  parameter logic [3:0]  HDR_TAG     = 4'hA
) (
  input  logic                           clock,
  input  logic                           reset_n,
  input  logic [NUM_SRC-1:0]             req,
  input  logic [NUM_SRC*PACKET_SIZE-1:0] packet_in,
  output logic [NUM_SRC-1:0]             buf_clear,
  output logic [10:0]                    word_out,
  output logic                           word_valid,
  input  logic                           word_ready,
  output logic                           busy,
  output logic [3:0]                     active_src
);

  localparam int unsigned SRC_W     = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;
  localparam int unsigned NUM_BYTES = PACKET_SIZE / 8;
  localparam int unsigned IDX_W     = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(NUM_BYTES - 1);
  localparam logic [10:0]      IDLE_WORD = 11'h7FF;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    HEADER = 2'd1,
    DATA   = 2'd2
  } state_e;

  // Frame a byte: stop, even parity, data LSB-first, start.
  function automatic logic [10:0] uart_word(input logic [7:0] b);
    return {1'b1, ^b, b, 1'b0};
  endfunction

  // Byte idx of the packet counted from the most-significant end.
  function automatic logic [7:0] pkt_byte(input logic [PACKET_SIZE-1:0] pkt,
                                          input logic [IDX_W-1:0]       idx);
    logic [PACKET_SIZE-1:0] sh;
    sh = pkt << (32'd8 * 32'(idx));
    return sh[PACKET_SIZE-1 -: 8];
  endfunction

  state_e                 state_q, state_d;
  logic [SRC_W-1:0]       last_q, last_d;
  logic [3:0]             active_src_q, active_src_d;
  logic [PACKET_SIZE-1:0] shadow_q, shadow_d;
  logic [IDX_W-1:0]       byte_idx_q, byte_idx_d;
  logic [NUM_SRC-1:0]     buf_clear_q, buf_clear_d;
  logic                   word_valid_q, word_valid_d;
  logic [10:0]            word_out_q, word_out_d;
  logic                   busy_q, busy_d;

  logic [SRC_W-1:0]       grant_c;
  logic                   grant_found_c;
  logic [PACKET_SIZE-1:0] pkt_sel_c;
  logic [NUM_SRC-1:0]     clr_sel_c;
  logic [31:0]            cand_c;
  logic                   hs_c;

  // Round-robin search starting after the last grant; nearest candidate wins.
  always_comb begin
    grant_c       = '0;
    grant_found_c = 1'b0;
    cand_c        = '0;
    pkt_sel_c     = '0;
    clr_sel_c     = '0;
    for (int i = NUM_SRC; i >= 1; i--) begin
      cand_c = 32'(last_q) + 32'(i);
      if (cand_c >= NUM_SRC) cand_c = cand_c - NUM_SRC;
      if (req[SRC_W'(cand_c)]) begin
        grant_c       = SRC_W'(cand_c);
        grant_found_c = 1'b1;
      end
    end
    for (int s = 0; s < NUM_SRC; s++) begin
      if (grant_c == SRC_W'(s)) begin
        pkt_sel_c    = packet_in[s*PACKET_SIZE +: PACKET_SIZE];
        clr_sel_c[s] = 1'b1;
      end
    end
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d      = state_q;
    last_d       = last_q;
    active_src_d = active_src_q;
    shadow_d     = shadow_q;
    byte_idx_d   = byte_idx_q;
    buf_clear_d  = '0;
    word_valid_d = word_valid_q;
    word_out_d   = word_out_q;
    hs_c         = word_valid_q & word_ready;

    case (state_q)
      IDLE: begin
        if (grant_found_c) begin
          shadow_d     = pkt_sel_c;
          active_src_d = 4'(grant_c);
          last_d       = grant_c;
          buf_clear_d  = clr_sel_c;
          word_valid_d = 1'b1;
          word_out_d   = uart_word({HDR_TAG, 4'(grant_c)});
          state_d      = HEADER;
        end
      end
      HEADER: begin
        if (hs_c) begin
          byte_idx_d = '0;
          word_out_d = uart_word(pkt_byte(shadow_q, '0));
          state_d    = DATA;
        end
      end
      DATA: begin
        if (hs_c) begin
          if (byte_idx_q == LAST_IDX) begin
            word_valid_d = 1'b0;
            word_out_d   = IDLE_WORD;
            state_d      = IDLE;
          end else begin
            byte_idx_d = byte_idx_q + IDX_W'(1);
            word_out_d = uart_word(pkt_byte(shadow_q, byte_idx_q + IDX_W'(1)));
          end
        end
      end
      default: begin
        state_d      = IDLE;
        word_valid_d = 1'b0;
        word_out_d   = IDLE_WORD;
      end
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers; reset aborts any transfer in progress.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      last_q       <= SRC_W'(NUM_SRC - 1);
      active_src_q <= '0;
      shadow_q     <= '0;
      byte_idx_q   <= '0;
      buf_clear_q  <= '0;
      word_valid_q <= 1'b0;
      word_out_q   <= IDLE_WORD;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_q       <= last_d;
      active_src_q <= active_src_d;
      shadow_q     <= shadow_d;
      byte_idx_q   <= byte_idx_d;
      buf_clear_q  <= buf_clear_d;
      word_valid_q <= word_valid_d;
      word_out_q   <= word_out_d;
      busy_q       <= busy_d;
    end
  end

  assign buf_clear  = buf_clear_q;
  assign word_out   = word_out_q;
  assign word_valid = word_valid_q;
  assign busy       = busy_q;
  assign active_src = active_src_q;

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler: stimulus queues expected grants and
// words; a negedge monitor pops and compares on every handshake / clear pulse.
module tb_uart_tx_scheduler;

  logic        clock;
  logic        reset_n;
  logic [1:0]  req;
  logic [63:0] packet_in;
  logic [1:0]  buf_clear;
  logic [10:0] word_out;
  logic        word_valid;
  logic        word_ready;
  logic        busy;
  logic [3:0]  active_src;

  int checks = 0;
  int errors = 0;
  int ready_mode = 0;

  logic [10:0] exp_words[$];
  int          exp_grant[$];

  uart_tx_scheduler #(.NUM_SRC(2), .PACKET_SIZE(32), .HDR_TAG(4'hA)) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .req        (req),
    .packet_in  (packet_in),
    .buf_clear  (buf_clear),
    .word_out   (word_out),
    .word_valid (word_valid),
    .word_ready (word_ready),
    .busy       (busy),
    .active_src (active_src)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Serializer model: always ready, or ready one cycle in sixteen.
  initial begin
    int rcyc;
    rcyc = 0;
    word_ready = 1'b0;
    forever begin
      @(posedge clock);
      #1;
      rcyc++;
      word_ready = (ready_mode == 0) ? 1'b1 : ((rcyc % 16) == 0);
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [10:0] mkw(input logic [7:0] b);
    return {1'b1, ^b, b, 1'b0};
  endfunction

  task automatic push_pkt(input int src, input logic [31:0] p);
    exp_grant.push_back(src);
    exp_words.push_back(mkw({4'hA, 4'(src)}));
    for (int b = 0; b < 4; b++) exp_words.push_back(mkw(p[31-8*b -: 8]));
  endtask

  task automatic wait_clear(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      #2;
      n++;
    end while (buf_clear == 2'b00 && n < budget);
    if (buf_clear == 2'b00) begin
      checks++;
      errors++;
      $display("FAIL wait_clear timeout actual=0 required=nonzero");
    end
  endtask

  task automatic wait_drain(input int budget);
    int n;
    n = 0;
    do begin
      @(negedge clock);
      #2;
      n++;
    end while (exp_words.size() != 0 && n < budget);
    if (exp_words.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL wait_drain timeout actual=%0d required=0 words left", exp_words.size());
      exp_words.delete();
    end
  endtask

  // Monitor: handshake words, hold stability under stall, clear pulses.
  logic        prev_valid = 1'b0;
  logic        prev_hs    = 1'b0;
  logic [10:0] prev_word  = 11'h7FF;
  always @(negedge clock) begin
    logic [10:0] e;
    logic [1:0]  exp_clr;
    int          g;
    if (!reset_n) begin
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
    end else begin
      if (prev_valid && !prev_hs) begin
        checks++;
        if (!word_valid || word_out !== prev_word) begin
          errors++;
          $display("FAIL stall_hold actual=v%0b/%03h required=v1/%03h", word_valid, word_out, prev_word);
        end
      end
      if (word_valid && word_ready) begin
        checks++;
        if (exp_words.size() == 0) begin
          errors++;
          $display("FAIL word_unexpected actual=%03h required=none", word_out);
        end else begin
          e = exp_words.pop_front();
          if (word_out !== e) begin
            errors++;
            $display("FAIL word actual=%03h required=%03h", word_out, e);
          end
        end
      end
      if (buf_clear != 2'b00) begin
        checks++;
        if (exp_grant.size() == 0) begin
          errors++;
          $display("FAIL buf_clear_unexpected actual=%b required=00", buf_clear);
        end else begin
          g = exp_grant.pop_front();
          exp_clr = 2'b00;
          exp_clr[g] = 1'b1;
          if (buf_clear !== exp_clr || active_src !== 4'(g)) begin
            errors++;
            $display("FAIL grant actual=clr%b/src%0d required=clr%b/src%0d", buf_clear, active_src, exp_clr, g);
          end
        end
      end
      prev_valid = word_valid;
      prev_hs    = word_valid && word_ready;
      prev_word  = word_out;
    end
  end

  initial begin
    time t0, t1;
    reset_n   = 1'b1;
    req       = 2'b00;
    packet_in = 64'h0;
    #1 reset_n = 1'b0;
    #2;
    chk("rst_valid", 32'(word_valid), 32'd0);
    chk("rst_word", 32'(word_out), 32'h7FF);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_src", 32'(active_src), 32'd0);
    chk("rst_clear", 32'(buf_clear), 32'd0);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;

    // Single packet, zero stall; words hand-framed.
    packet_in[31:0] = 32'hDEADBEEF;
    req = 2'b01;
    exp_grant.push_back(0);
    exp_words.push_back(11'b1_0_10100000_0);
    exp_words.push_back(11'b1_0_11011110_0);
    exp_words.push_back(11'b1_1_10101101_0);
    exp_words.push_back(11'b1_0_10111110_0);
    exp_words.push_back(11'b1_1_11101111_0);
    wait_clear(20);
    t0 = $time;
    @(posedge clock); #1 req = 2'b00;
    wait_drain(50);
    t1 = $time;
    chk("t1_back2back", 32'(t1 - t0), 32'd40);
    chk("t1_busy_last", 32'(busy), 32'd1);
    @(posedge clock); #1;
    chk("t1_busy_end", 32'(busy), 32'd0);
    chk("t1_valid_end", 32'(word_valid), 32'd0);
    chk("t1_word_end", 32'(word_out), 32'h7FF);

    // Backpressure: ready 1 cycle in 16.
    ready_mode = 1;
    packet_in[63:32] = 32'h01234567;
    req = 2'b10;
    push_pkt(1, 32'h01234567);
    wait_clear(20);
    @(posedge clock); #1 req = 2'b00;
    wait_drain(400);
    @(posedge clock); #1;
    chk("t2_busy_end", 32'(busy), 32'd0);
    ready_mode = 0;
    repeat (2) @(posedge clock);
    #1;

    // Round-robin with both requesters.
    packet_in = {32'h89ABCDEF, 32'h55AA0FF0};
    push_pkt(0, 32'h55AA0FF0);
    push_pkt(1, 32'h89ABCDEF);
    push_pkt(0, 32'h55AA0FF0);
    push_pkt(1, 32'h89ABCDEF);
    req = 2'b11;
    for (int k = 0; k < 4; k++) begin
      wait_clear(40);
      @(posedge clock); #1;
      if (k == 3) begin
        req = 2'b00;
      end else begin
        req[k % 2] = 1'b0;
        repeat (2) @(posedge clock);
        #1 req[k % 2] = 1'b1;
      end
    end
    wait_drain(60);
    chk("t3_grants_left", 32'(exp_grant.size()), 32'd0);
    repeat (3) @(posedge clock);
    #1;

    // Mid-transfer req drop and packet change.
    packet_in[31:0] = 32'hCAFEF00D;
    req = 2'b01;
    push_pkt(0, 32'hCAFEF00D);
    wait_clear(20);
    @(posedge clock); #1;
    @(posedge clock); #1;
    req = 2'b00;
    packet_in = {32'h22222222, 32'h11111111};
    wait_drain(60);
    repeat (6) @(posedge clock);
    #1;
    chk("t4_busy_idle", 32'(busy), 32'd0);

    // Reset during data byte 2.
    packet_in[63:32] = 32'h89ABCDEF;
    req = 2'b10;
    exp_grant.push_back(1);
    exp_words.push_back(mkw(8'hA1));
    exp_words.push_back(mkw(8'h89));
    exp_words.push_back(mkw(8'hAB));
    wait_clear(20);
    @(posedge clock); #1 req = 2'b00;
    wait_drain(40);
    @(posedge clock);
    #3 reset_n = 1'b0;
    #1;
    chk("t5_valid", 32'(word_valid), 32'd0);
    chk("t5_word", 32'(word_out), 32'h7FF);
    chk("t5_busy", 32'(busy), 32'd0);
    chk("t5_clear", 32'(buf_clear), 32'd0);
    chk("t5_src", 32'(active_src), 32'd0);
    req = 2'b11;
    packet_in = {32'h02468ACE, 32'h13579BDF};
    push_pkt(0, 32'h13579BDF);
    @(negedge clock);
    #1 reset_n = 1'b1;
    wait_clear(20);
    @(posedge clock); #1 req = 2'b00;
    wait_drain(40);
    repeat (3) @(posedge clock);
    #1;

    // Re-grant: req0 held through its clear.
    packet_in[31:0] = 32'h0F1E2D3C;
    req = 2'b01;
    push_pkt(0, 32'h0F1E2D3C);
    push_pkt(0, 32'h4B5A6978);
    wait_clear(20);
    t0 = $time;
    @(posedge clock); #1 packet_in[31:0] = 32'h4B5A6978;
    wait_clear(40);
    t1 = $time;
    chk("t6_regrant_gap", 32'(t1 - t0), 32'd60);
    @(posedge clock); #1 req = 2'b00;
    wait_drain(40);
    repeat (4) @(posedge clock);
    #1;
    chk("end_words_left", 32'(exp_words.size()), 32'd0);
    chk("end_grants_left", 32'(exp_grant.size()), 32'd0);
    chk("end_busy", 32'(busy), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
